// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 scan sequencer.
//   - bit positions of the 6-bit LTC2308 config word {S/D, O/S, S1, S0, UNI, SLP}
//   - conf_word(): single-ended config word for a channel
//   - scan FSM state encoding
//   - default result width / channel count
package adc_pkg;

  localparam int W_DEF   = 12;
  localparam int NCH_DEF = 8;

  localparam int CONF_SD  = 5;
  localparam int CONF_OS  = 4;
  localparam int CONF_S1  = 3;
  localparam int CONF_S0  = 2;
  localparam int CONF_UNI = 1;
  localparam int CONF_SLP = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_SETUP,
    ST_START,
    ST_WAIT_CONV,
    ST_STORE,
    ST_NEXT
  } state_t;

  // Single-ended, never sleep. The LTC2308 channel address is scrambled:
  // O/S carries ch[0], S1 carries ch[2], S0 carries ch[1].
  function automatic logic [5:0] conf_word(input logic [2:0] ch, input logic uni);
    logic [5:0] c;
    c           = '0;
    c[CONF_SD]  = 1'b1;
    c[CONF_OS]  = ch[0];
    c[CONF_S1]  = ch[2];
    c[CONF_S0]  = ch[1];
    c[CONF_UNI] = uni;
    c[CONF_SLP] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Scan period timer. Counts 0..period while en=1 and flags tick on the
// cycle the count equals period (tick every period+1 cycles; period=0 ticks
// every cycle). Held at 0 while en=0.
// Ports:
//   clk, rst     clock / async active-low reset
//   en           run enable
//   period       terminal count (period length minus 1)
//   tick         combinational wrap strobe
module adc_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;

  assign tick = en && (cnt == period);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (!en)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic channel scanner for the LTC2308 SPI driver. On each period tick
// it walks the enabled channels lowest-first: loads the config word, pulses
// drv_start, waits for a drv_ready rising edge (or times out) and stores the
// result in a per-channel bank.
// Ports:
//   clk, rst                 clock / async active-low reset
//   en, ch_mask, uni, period scan control (mask and uni latched per scan)
//   drv_conf, drv_start      to the driver
//   drv_res, drv_ready       from the driver
//   rd_ch, rd_data           combinational result bank read
//   sample_valid/ch/data     one-cycle pulse per stored result
//   scan_done                pulse after the last channel of a full scan
//   busy                     scan in progress
//   overrun, timeout_err     sticky, cleared on reset or en falling
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int PERIOD_W  = 16,
  parameter int START_CYC = 2,
  parameter int TMO       = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NCH-1:0]      ch_mask,
  input  logic                uni,
  input  logic [PERIOD_W-1:0] period,
  output logic [5:0]          drv_conf,
  output logic                drv_start,
  input  logic [W-1:0]        drv_res,
  input  logic                drv_ready,
  input  logic [2:0]          rd_ch,
  output logic [W-1:0]        rd_data,
  output logic                sample_valid,
  output logic [2:0]          sample_ch,
  output logic [W-1:0]        sample_data,
  output logic                scan_done,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TMO + 1);

  state_t                  state, state_nxt;
  logic                    tick;
  logic [NCH-1:0]          scan_mask, remain;
  logic [2:0]              ch, first_ch, next_ch;
  logic                    uni_q, rdy_q, en_q, rdy_edge;
  logic [CNT_W-1:0]        cnt;
  logic [NCH-1:0][W-1:0]   bank;

  adc_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .tick   (tick)
  );

  assign rdy_edge = drv_ready & ~rdy_q;
  assign remain   = scan_mask & ~(NCH'(1) << ch);

  // lowest set bit of the live mask (scan start) and of what is left
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
      if (remain[i])  next_ch  = 3'(i);
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (en) state_nxt = ST_WAIT_TICK;
      ST_WAIT_TICK: if (!en) state_nxt = ST_IDLE;
                    else if (tick && |ch_mask) state_nxt = ST_SETUP;
      ST_SETUP:     state_nxt = ST_START;
      ST_START:     if (cnt == CNT_W'(START_CYC-1)) state_nxt = ST_WAIT_CONV;
      ST_WAIT_CONV: if (rdy_edge) state_nxt = ST_STORE;
                    else if (cnt == CNT_W'(TMO-1)) state_nxt = ST_NEXT;
      ST_STORE:     state_nxt = ST_NEXT;
      // en low: finish here without scan_done, even if channels remain
      ST_NEXT:      if (!en) state_nxt = ST_IDLE;
                    else if (|remain) state_nxt = ST_SETUP;
                    else state_nxt = ST_WAIT_TICK;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy         = !(state == ST_IDLE || state == ST_WAIT_TICK);
    drv_start    = (state == ST_START);
    sample_valid = (state == ST_STORE);
    sample_ch    = sample_valid ? ch : 3'd0;
    sample_data  = sample_valid ? drv_res : '0;
    scan_done    = (state == ST_NEXT) && en && !(|remain);
  end

  // datapath: per-state cycle counter, scan latches, bank, sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      scan_mask   <= '0;
      ch          <= '0;
      uni_q       <= 1'b0;
      rdy_q       <= 1'b0;
      en_q        <= 1'b0;
      drv_conf    <= '0;
      bank        <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rdy_q <= drv_ready;
      en_q  <= en;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;

      // drv_conf is loaded on entry to SETUP so it leads drv_start by a cycle
      if (state == ST_WAIT_TICK && state_nxt == ST_SETUP) begin
        scan_mask <= ch_mask;
        ch        <= first_ch;
        uni_q     <= uni;
        drv_conf  <= conf_word(first_ch, uni);
      end
      if (state == ST_NEXT) begin
        scan_mask <= remain;
        if (state_nxt == ST_SETUP) begin
          ch       <= next_ch;
          drv_conf <= conf_word(next_ch, uni_q);
        end
      end

      if (state == ST_STORE) bank[ch] <= drv_res;

      if (en_q && !en) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (tick && busy) overrun <= 1'b1;
      if (state == ST_WAIT_CONV && state_nxt == ST_NEXT) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_ch) < NCH) rd_data = bank[rd_ch];
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, uni = 1'b0, drv_ready = 1'b1;
  logic [7:0]  ch_mask = '0;
  logic [15:0] period = '0;
  logic [11:0] drv_res = '0;
  logic [2:0]  rd_ch = '0;
  logic [5:0]  drv_conf;
  logic        drv_start, sample_valid, scan_done, busy, overrun, timeout_err;
  logic [11:0] rd_data, sample_data;
  logic [2:0]  sample_ch;

  adc_scan_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .uni(uni), .period(period),
    .drv_conf(drv_conf), .drv_start(drv_start), .drv_res(drv_res), .drv_ready(drv_ready),
    .rd_ch(rd_ch), .rd_data(rd_data), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .scan_done(scan_done), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // driver model controls
  int          lat = 5;
  int          dead_ch = -1;
  logic        fixed_mode = 1'b0;
  logic [11:0] fixed_val = '0;

  // driver model: ready drops on start, rises lat cycles after start ends.
  // Channel decoded from the LTC2308 word: ch = {S1, S0, O/S}.
  logic       conv = 1'b0;
  int         cd = 0;
  logic [2:0] cch = '0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      drv_ready = 1'b1; conv = 1'b0;
    end else if (drv_start) begin
      drv_ready = 1'b0; conv = 1'b1; cd = lat;
      cch = {drv_conf[3], drv_conf[2], drv_conf[4]};
    end else if (conv && int'(cch) != dead_ch) begin
      if (cd == 0) begin
        drv_res   = fixed_mode ? fixed_val : 12'h100 + 12'(cch);
        drv_ready = 1'b1;
        conv      = 1'b0;
      end else cd--;
    end
  end

  // monitor
  int          cyc = 0, cur_run = 0, tmo_rise_cyc = 0, conf_pre_bad = 0;
  logic        prev_start = 1'b0, prev_tmo = 1'b0;
  logic [5:0]  prev_conf = '0;
  logic [2:0]  s_ch[$];
  logic [11:0] s_data[$];
  logic [5:0]  conf_q[$];
  int          start_rise_cyc[$], start_runs[$], fall_cyc[$], done_cyc[$], done_nsamp[$];
  initial forever begin
    @(negedge clk);
    cyc++;
    if (drv_start && !prev_start) begin
      conf_q.push_back(drv_conf);
      start_rise_cyc.push_back(cyc);
      if (prev_conf !== drv_conf) conf_pre_bad++;
    end
    if (drv_start) cur_run++;
    else if (prev_start) begin
      start_runs.push_back(cur_run); cur_run = 0; fall_cyc.push_back(cyc);
    end
    if (sample_valid) begin s_ch.push_back(sample_ch); s_data.push_back(sample_data); end
    if (scan_done) begin done_cyc.push_back(cyc); done_nsamp.push_back(s_ch.size()); end
    if (timeout_err && !prev_tmo) tmo_rise_cyc = cyc;
    prev_start = drv_start; prev_tmo = timeout_err; prev_conf = drv_conf;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    s_ch.delete(); s_data.delete(); conf_q.delete(); start_rise_cyc.delete();
    start_runs.delete(); fall_cyc.delete(); done_cyc.delete(); done_nsamp.delete();
    cur_run = 0; conf_pre_bad = 0; prev_start = 1'b0; prev_tmo = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    clear_mon();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; ch_mask = 8'hFF; period = 16'd0; rd_ch = 3'd0;
    step(); step();
    n_chk++; if (drv_conf !== 6'd0) $display("FAIL reset_conf: got %b exp 0", drv_conf); else n_pass++;
    n_chk++; if (drv_start !== 1'b0) $display("FAIL reset_start: got %b exp 0", drv_start); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if ({sample_valid, scan_done, overrun, timeout_err} !== 4'b0)
      $display("FAIL reset_flags: got %b exp 0000", {sample_valid, scan_done, overrun, timeout_err}); else n_pass++;
    n_chk++; if (rd_data !== 12'd0) $display("FAIL reset_rd: got %h exp 000", rd_data); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_single();
    int en_cyc;
    do_reset();
    uni = 1'b1; ch_mask = 8'h01; period = 16'd999; lat = 5;
    fixed_mode = 1'b1; fixed_val = 12'hABC;
    en = 1'b1; en_cyc = cyc;
    for (int i = 0; i < 2300 && done_cyc.size() < 2; i++) step();
    n_chk++; if (done_cyc.size() < 2) $display("FAIL single_done: got %0d scans exp 2", done_cyc.size()); else n_pass++;
    n_chk++; if (start_rise_cyc[0] - en_cyc !== 1001)
      $display("FAIL single_latency: got %0d exp 1001", start_rise_cyc[0] - en_cyc); else n_pass++;
    n_chk++; if (conf_q[0] !== 6'b100010) $display("FAIL single_conf: got %b exp 100010", conf_q[0]); else n_pass++;
    n_chk++; if (start_runs[0] !== 2) $display("FAIL single_start_len: got %0d exp 2", start_runs[0]); else n_pass++;
    n_chk++; if (done_nsamp[0] !== 1) $display("FAIL single_nsamp: got %0d exp 1", done_nsamp[0]); else n_pass++;
    n_chk++; if ({s_ch[0], s_data[0]} !== {3'd0, 12'hABC})
      $display("FAIL single_sample: got ch%0d %h exp ch0 ABC", s_ch[0], s_data[0]); else n_pass++;
    n_chk++; if (done_cyc[1] - done_cyc[0] !== 1000)
      $display("FAIL single_period: got %0d exp 1000", done_cyc[1] - done_cyc[0]); else n_pass++;
    rd_ch = 3'd0; #1;
    n_chk++; if (rd_data !== 12'hABC) $display("FAIL single_bank0: got %h exp ABC", rd_data); else n_pass++;
    en = 1'b0; fixed_mode = 1'b0;
    step();
  endtask

  task automatic test_mask();
    do_reset();
    uni = 1'b1; ch_mask = 8'hA5; period = 16'd200; lat = 5;
    en = 1'b1;
    for (int i = 0; i < 400 && !busy; i++) step();
    uni = 1'b0; ch_mask = 8'h0F;   // must not affect the scan in flight
    for (int i = 0; i < 400 && done_cyc.size() < 1; i++) step();
    en = 1'b0;
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL mask_done: got %0d exp 1", done_cyc.size()); else n_pass++;
    n_chk++; if ({s_ch[0], s_ch[1], s_ch[2], s_ch[3]} !== {3'd0, 3'd2, 3'd5, 3'd7} || s_ch.size() != 4)
      $display("FAIL mask_order: got %0d,%0d,%0d,%0d exp 0,2,5,7", s_ch[0], s_ch[1], s_ch[2], s_ch[3]); else n_pass++;
    n_chk++; if (s_data[2] !== 12'h105) $display("FAIL mask_data5: got %h exp 105", s_data[2]); else n_pass++;
    n_chk++; if (conf_q[2] !== 6'b111010) $display("FAIL mask_conf5: got %b exp 111010", conf_q[2]); else n_pass++;
    n_chk++; if (conf_pre_bad !== 0) $display("FAIL mask_conf_lead: got %0d late loads exp 0", conf_pre_bad); else n_pass++;
    rd_ch = 3'd1; #1;
    n_chk++; if (rd_data !== 12'h000) $display("FAIL mask_bank1: got %h exp 000", rd_data); else n_pass++;
    rd_ch = 3'd7; #1;
    n_chk++; if (rd_data !== 12'h107) $display("FAIL mask_bank7: got %h exp 107", rd_data); else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    uni = 1'b1; ch_mask = 8'h03; period = 16'd999; lat = 5; dead_ch = 0;
    en = 1'b1;
    for (int i = 0; i < 1700 && done_cyc.size() < 1; i++) step();
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL tmo_done: got %0d exp 1", done_cyc.size()); else n_pass++;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL tmo_flag: got %b exp 1", timeout_err); else n_pass++;
    n_chk++; if (tmo_rise_cyc - fall_cyc[0] !== 255)
      $display("FAIL tmo_cycles: got %0d exp 255", tmo_rise_cyc - fall_cyc[0]); else n_pass++;
    n_chk++; if (s_ch.size() !== 1 || s_ch[0] !== 3'd1)
      $display("FAIL tmo_samples: got n=%0d ch%0d exp n=1 ch1", s_ch.size(), s_ch[0]); else n_pass++;
    rd_ch = 3'd0; #1;
    n_chk++; if (rd_data !== 12'h000) $display("FAIL tmo_bank0: got %h exp 000", rd_data); else n_pass++;
    en = 1'b0; dead_ch = -1;
    step(); step();
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_clear: got %b exp 0", timeout_err); else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    uni = 1'b0; ch_mask = 8'hFF; period = 16'd10; lat = 3;
    en = 1'b1;
    for (int i = 0; i < 1000 && done_cyc.size() < 2; i++) step();
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b exp 1", overrun); else n_pass++;
    n_chk++; if (done_nsamp[0] !== 8 || done_nsamp[1] !== 16)
      $display("FAIL ovr_counts: got %0d,%0d exp 8,16", done_nsamp[0], done_nsamp[1]); else n_pass++;
    begin
      int bad = 0;
      for (int i = 0; i < 16; i++) if (s_ch[i] !== 3'(i % 8)) bad++;
      n_chk++; if (bad != 0) $display("FAIL ovr_order: got %0d misordered exp 0", bad); else n_pass++;
    end
    n_chk++; if (conf_q[3] !== 6'b110100) $display("FAIL ovr_conf3: got %b exp 110100", conf_q[3]); else n_pass++;
    en = 1'b0;
    step(); step();
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b exp 0", overrun); else n_pass++;
  endtask

  task automatic test_en_drop();
    do_reset();
    uni = 1'b1; ch_mask = 8'hFF; period = 16'd99; lat = 20;
    en = 1'b1;
    for (int i = 0; i < 600 && fall_cyc.size() < 4; i++) step();
    en = 1'b0;   // ch3 now waiting for ready
    for (int i = 0; i < 60; i++) step();
    n_chk++; if (s_ch.size() !== 4 || s_ch[3] !== 3'd3 || s_data[3] !== 12'h103)
      $display("FAIL drop_store: got n=%0d ch%0d %h exp n=4 ch3 103", s_ch.size(), s_ch[3], s_data[3]); else n_pass++;
    n_chk++; if (start_rise_cyc.size() !== 4) $display("FAIL drop_starts: got %0d exp 4", start_rise_cyc.size()); else n_pass++;
    n_chk++; if (done_cyc.size() !== 0) $display("FAIL drop_done: got %0d exp 0", done_cyc.size()); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b exp 0", busy); else n_pass++;
    rd_ch = 3'd3; #1;
    n_chk++; if (rd_data !== 12'h103) $display("FAIL drop_bank3: got %h exp 103", rd_data); else n_pass++;
    rd_ch = 3'd4; #1;
    n_chk++; if (rd_data !== 12'h000) $display("FAIL drop_bank4: got %h exp 000", rd_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    uni = 1'b1; ch_mask = 8'h01; period = 16'd5; lat = 2;
    en = 1'b1;
    for (int i = 0; i < 200 && done_cyc.size() < 1; i++) step();
    for (int i = 0; i < 200 && !drv_start; i++) step();
    rd_ch = 3'd0; #1;
    n_chk++; if (rd_data !== 12'h100 || drv_start !== 1'b1)
      $display("FAIL mid_setup: got %h start=%b exp 100 start=1", rd_data, drv_start); else n_pass++;
    rst = 1'b0; #1;
    n_chk++; if (drv_start !== 1'b0) $display("FAIL mid_start: got %b exp 0", drv_start); else n_pass++;
    n_chk++; if (rd_data !== 12'h000) $display("FAIL mid_bank: got %h exp 000", rd_data); else n_pass++;
    n_chk++; if ({busy, sample_valid, scan_done, overrun, timeout_err, drv_conf} !== 11'd0)
      $display("FAIL mid_flags: got %b exp 0", {busy, sample_valid, scan_done, overrun, timeout_err, drv_conf}); else n_pass++;
    en = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    rst = 1'b1;
    test_single();
    test_mask();
    test_timeout();
    test_overrun();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Sequences the LTC2308 SPI driver through a programmable set of single-ended channels on a periodic scan timer. For each enabled channel it builds the driver's 6-bit config word, pulses start, waits for ready and latches the result into a per-channel result bank. It sits between the board-level top (LEDs/host logic) and the ADC driver, and replaces the free-running start counter.

Parameters:
W, 12, ADC result width (matches driver res width)
NCH, 8, number of channels scanned (LTC2308 CH0..CH7)
PERIOD_W, 16, width of scan-period register
START_CYC, 2, cycles drv_start is held high per conversion
TMO, 255, max cycles to wait for drv_ready before declaring timeout

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
en  in  1  scan enable
ch_mask  in  NCH  bit n=1 scans channel n
uni  in  1  1=unipolar, 0=bipolar (UNI bit of config word)
period  in  PERIOD_W  scan period, in clk cycles, minus 1
drv_conf  out  6  config word to driver: {S/D, O/S, S1, S0, UNI, SLP}
drv_start  out  1  start request to driver
drv_res  in  W  driver result
drv_ready  in  1  driver ready level
rd_ch  in  3  result bank read address
rd_data  out  W  combinational read of bank[rd_ch]; 0 if rd_ch>=NCH
sample_valid  out  1  one-cycle pulse per stored result
sample_ch  out  3  channel of sample_valid
sample_data  out  W  result of sample_valid
scan_done  out  1  one-cycle pulse after last enabled channel of a scan
busy  out  1  high in any state except IDLE/WAIT_TICK
overrun  out  1  sticky: tick arrived while scan still busy
timeout_err  out  1  sticky: drv_ready not seen within TMO cycles

Behaviour:
- Reset (rst=0, async): all outputs 0, bank all 0, state IDLE, timer 0, sticky flags 0.
- Config word for channel n: S/D=1, O/S=n[0], S1=n[2], S0=n[1], UNI=uni, SLP=0. drv_conf is registered and is stable from one cycle before drv_start rises until drv_ready is seen.
- Period timer: runs while en=1; counts 0..period, tick on wrap (tick every period+1 cycles; period=0 -> tick every cycle). Held at 0 while en=0.
- FSM:
  IDLE: en=1 -> WAIT_TICK.
  WAIT_TICK: en=0 -> IDLE; tick and ch_mask!=0 -> capture mask into scan_mask, ch=lowest set bit, -> SETUP; tick with mask=0 -> stay, no scan_done.
  SETUP (1 cycle): load drv_conf for ch -> START.
  START: drv_start=1 for exactly START_CYC cycles -> WAIT_CONV.
  WAIT_CONV: registered rising edge of drv_ready (prev=0, now=1) -> STORE; wait counter reaches TMO -> set timeout_err, no store, -> NEXT.
  STORE (1 cycle): bank[ch]<=drv_res; sample_valid=1, sample_ch=ch, sample_data=drv_res -> NEXT.
  NEXT: clear scan_mask[ch]; remaining bits -> ch=next lowest set bit, SETUP; none -> scan_done pulse, -> WAIT_TICK (IDLE if en=0).
- Latency: drv_start rises 2 cycles after the tick (SETUP + 1); sample_valid 1 cycle after the ready edge is registered.
- ch_mask and uni changes mid-scan take effect at the next scan only (scan_mask and the uni bit are latched at scan start).
- en=0 mid-scan: the in-flight conversion completes and is stored (or times out), then FSM -> IDLE; no further channels, no scan_done.
- Tick while busy: overrun<=1, tick dropped (never queued). overrun and timeout_err clear only on reset or on an en 1->0 transition.
- rd_data reflects a STORE on the cycle after it.

Decomposition:
- Shared package adc_pkg: LTC2308 config bit positions (S/D, O/S, S1, S0, UNI, SLP), conf_word(ch, uni) function, FSM state encoding, W/NCH defaults.
- One sub-module: adc_period_timer (counter, tick, en-hold); the FSM and result bank stay in adc_scan_sequencer.

Test Plan:
- en=1, ch_mask=8'h01, uni=1, period=999, driver model returns 12'hABC -> drv_conf=6'b100010, one drv_start of 2 cycles, sample_valid ch=0 data=ABC, scan_done, bank[0]=ABC; repeats every 1000 cycles.
- ch_mask=8'hA5, res=12'h100+ch -> sample_ch order 0,2,5,7; drv_conf for ch5 = 6'b111010 (uni=1); bank[1]=0; rd_ch=7 -> 12'h107.
- Driver never raises ready -> after TMO=255 wait cycles timeout_err=1, no sample_valid for that channel, next channel proceeds; en 1->0 clears timeout_err.
- period=10 with 8-channel scan (> 11 cycles) -> overrun=1, scans not queued, each scan still completes all 8 channels.
- en dropped during WAIT_CONV of ch3 (mask=FF) -> ch3 stored, no ch4 start, no scan_done, busy=0, state IDLE.
- rst=0 asserted mid-START -> drv_start=0 immediately (async), bank cleared, sample_valid/scan_done/flags 0.
